vga_box_compositor: RTL and testbench

//  Owns a table of N_BOXES rectangle descriptors and composites them per pixel into one RGB444 stream.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_box_hit.sv | 63 ++++++
 rtl/vga_box_compositor.sv | 149 ++++++++++++++
 tb/tb_vga_box_compositor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types for the VGA box compositor: descriptor struct, colour type, FSM states.
package vga_pkg;

  localparam int unsigned PixXW = 11;
  localparam int unsigned PixYW = 10;

  typedef logic [11:0] rgb444_t;

  typedef struct packed {
    logic             en;
    logic             outline;
    logic [PixXW-1:0] x;
    logic [PixXW-1:0] w;
    logic [PixYW-1:0] y;
    logic [PixYW-1:0] h;
    rgb444_t          rgb;
  } box_desc_t;

  typedef enum logic {S_RUN, S_COMMIT} comp_state_e;

endpackage

// File: rtl/vga_box_hit.sv
// One-slot hit test: descriptor and pixel in, registered hit/edge flags and fill colour out.
// Edge detection is only built with VGA_COMP_OUTLINE_EN; otherwise edge_o is constant 0.
module vga_box_hit
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  box_desc_t        desc_i,
  input  logic [PixXW-1:0] pix_x_i,
  input  logic [PixYW-1:0] pix_y_i,
  output logic             hit_o,
  output logic             edge_o,
  output rgb444_t          rgb_o
);

  // One extra bit on the far edges so boxes running past the screen limit do not wrap.
  logic [PixXW:0] x_end;
  logic [PixYW:0] y_end;
  logic           hit_d, hit_q;
  logic           edge_d, edge_q;
  rgb444_t        rgb_q;

  assign x_end = {1'b0, desc_i.x} + {1'b0, desc_i.w};
  assign y_end = {1'b0, desc_i.y} + {1'b0, desc_i.h};

  // Containment test; w=0 or h=0 makes the upper bound equal the lower bound, so never hits.
  always_comb begin
    hit_d = desc_i.en
          && (pix_x_i >= desc_i.x) && ({1'b0, pix_x_i} < x_end)
          && (pix_y_i >= desc_i.y) && ({1'b0, pix_y_i} < y_end);
  end

`ifdef VGA_COMP_OUTLINE_EN
  // Pixel lies on the first/last row or column of a box that wants an outline.
  always_comb begin
    edge_d = hit_d && desc_i.outline
          && ((pix_x_i == desc_i.x) || ({1'b0, pix_x_i} == x_end - 1'b1)
           || (pix_y_i == desc_i.y) || ({1'b0, pix_y_i} == y_end - 1'b1));
  end
`else
  logic unused_outline;
  assign unused_outline = desc_i.outline;
  assign edge_d = 1'b0;
`endif

  // Stage-1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= 1'b0;
      edge_q <= 1'b0;
      rgb_q  <= '0;
    end else begin
      hit_q  <= hit_d;
      edge_q <= edge_d;
      rgb_q  <= desc_i.rgb;
    end
  end

  assign hit_o  = hit_q;
  assign edge_o = edge_q;
  assign rgb_o  = rgb_q;

endmodule

// File: rtl/vga_box_compositor.sv
// Composites N_BOXES rectangles into one RGB444 stream with a 2-cycle pipeline.
// Descriptors are written to a shadow bank and copied to the active bank after frame_start.
// Optional outline rendering: define VGA_COMP_OUTLINE_EN.
module vga_box_compositor
  import vga_pkg::*;
#(
  parameter int unsigned N_BOXES     = 8,
  parameter rgb444_t     BG          = 12'h000,
  parameter rgb444_t     OUTLINE_RGB = 12'hFFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [10:0]                pix_x_in,
  input  logic [9:0]                 pix_y_in,
  input  logic                       in_screen,
  input  logic                       frame_start,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [$clog2(N_BOXES):0]   cfg_idx,
  input  logic                       cfg_en,
  input  logic                       cfg_outline,
  input  logic [10:0]                cfg_x,
  input  logic [10:0]                cfg_w,
  input  logic [9:0]                 cfg_y,
  input  logic [9:0]                 cfg_h,
  input  logic [11:0]                cfg_rgb,
  output logic                       cfg_err,
  output logic [3:0]                 VGA_R,
  output logic [3:0]                 VGA_G,
  output logic [3:0]                 VGA_B,
  output logic                       hit_valid,
  output logic [$clog2(N_BOXES)-1:0] hit_idx
);

  localparam int unsigned IdxW = $clog2(N_BOXES);

  comp_state_e state_d, state_q;
  box_desc_t   shadow_d [N_BOXES];
  box_desc_t   shadow_q [N_BOXES];
  box_desc_t   active_d [N_BOXES];
  box_desc_t   active_q [N_BOXES];
  box_desc_t   wr_desc;
  logic        transfer, idx_ok;
  logic        cfg_err_d, cfg_err_q;

  logic [N_BOXES-1:0] hit_s1, edge_s1;
  rgb444_t            rgb_s1 [N_BOXES];
  logic               in_screen_q;

  rgb444_t            pix_rgb_d, pix_rgb_q;
  logic               hit_valid_d, hit_valid_q;
  logic [IdxW-1:0]    hit_idx_d, hit_idx_q;

  assign cfg_ready = (state_q == S_RUN);
  assign transfer  = cfg_valid && cfg_ready;
  assign idx_ok    = (cfg_idx < (IdxW+1)'(N_BOXES));
  assign wr_desc   = '{en: cfg_en, outline: cfg_outline, x: cfg_x, w: cfg_w,
                       y: cfg_y, h: cfg_h, rgb: cfg_rgb};

  // Commit FSM: a single S_COMMIT cycle follows each frame_start seen in S_RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:    if (frame_start) state_d = S_COMMIT;
      S_COMMIT: state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  // Bank updates; a write in the frame_start cycle is already in shadow when S_COMMIT copies it.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    cfg_err_d = transfer && !idx_ok;
    if (transfer && idx_ok) shadow_d[cfg_idx[IdxW-1:0]] = wr_desc;
    if (state_q == S_COMMIT) active_d = shadow_q;
  end

  // Control and descriptor state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < N_BOXES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  assign cfg_err = cfg_err_q;

  // Stage 1: per-slot hit test.
  for (genvar i = 0; i < N_BOXES; i++) begin : g_box
    vga_box_hit u_hit (
      .clk     (clk),
      .rst_n   (rst_n),
      .desc_i  (active_q[i]),
      .pix_x_i (pix_x_in),
      .pix_y_i (pix_y_in),
      .hit_o   (hit_s1[i]),
      .edge_o  (edge_s1[i]),
      .rgb_o   (rgb_s1[i])
    );
  end

  // Stage 2 select: lowest-index hit wins; off-screen forces background.
  always_comb begin
    pix_rgb_d   = BG;
    hit_valid_d = 1'b0;
    hit_idx_d   = '0;
    if (in_screen_q) begin
      for (int i = N_BOXES - 1; i >= 0; i--) begin
        if (hit_s1[i]) begin
          hit_valid_d = 1'b1;
          hit_idx_d   = IdxW'(i);
          pix_rgb_d   = edge_s1[i] ? OUTLINE_RGB : rgb_s1[i];
        end
      end
    end
  end

  // Pipeline registers: in_screen delay for S1, colour/hit outputs for S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_screen_q <= 1'b0;
      pix_rgb_q   <= BG;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
    end else begin
      in_screen_q <= in_screen;
      pix_rgb_q   <= pix_rgb_d;
      hit_valid_q <= hit_valid_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  assign VGA_R     = pix_rgb_q[11:8];
  assign VGA_G     = pix_rgb_q[7:4];
  assign VGA_B     = pix_rgb_q[3:0];
  assign hit_valid = hit_valid_q;
  assign hit_idx   = hit_idx_q;

endmodule

// File: tb/tb_vga_box_compositor.sv
// Directed bench for vga_box_compositor; outline expectations follow VGA_COMP_OUTLINE_EN.
module tb_vga_box_compositor;

  logic        clk, rst_n;
  logic [10:0] pix_x_in;
  logic [9:0]  pix_y_in;
  logic        in_screen, frame_start, cfg_valid, cfg_ready;
  logic [3:0]  cfg_idx;
  logic        cfg_en, cfg_outline, cfg_err;
  logic [10:0] cfg_x, cfg_w;
  logic [9:0]  cfg_y, cfg_h;
  logic [11:0] cfg_rgb;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        hit_valid;
  logic [2:0]  hit_idx;

  int n_cmp = 0;
  int n_bad = 0;

  vga_box_compositor dut (
    .clk(clk), .rst_n(rst_n), .pix_x_in(pix_x_in), .pix_y_in(pix_y_in),
    .in_screen(in_screen), .frame_start(frame_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_outline(cfg_outline),
    .cfg_x(cfg_x), .cfg_w(cfg_w), .cfg_y(cfg_y), .cfg_h(cfg_h), .cfg_rgb(cfg_rgb),
    .cfg_err(cfg_err), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .hit_valid(hit_valid), .hit_idx(hit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer.
  task automatic cfg_write(input logic [3:0] idx, input logic en, input logic ol,
                           input logic [10:0] x, input logic [10:0] w,
                           input logic [9:0] y, input logic [9:0] h, input logic [11:0] rgb);
    int cnt = 0;
    cfg_idx = idx; cfg_en = en; cfg_outline = ol;
    cfg_x = x; cfg_w = w; cfg_y = y; cfg_h = h; cfg_rgb = rgb;
    cfg_valid = 1'b1;
    while (!cfg_ready && cnt < 10) begin
      @(posedge clk); #1; cnt++;
    end
    if (cnt >= 10) check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Present one pixel and check the outputs two cycles later.
  task automatic probe(input string tag, input logic [10:0] x, input logic [9:0] y,
                       input logic scr, input logic [11:0] exp_rgb,
                       input logic exp_hv, input logic [2:0] exp_idx);
    pix_x_in = x; pix_y_in = y; in_screen = scr;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_rgb));
    check({tag, "_hv"}, 32'(hit_valid), 32'(exp_hv));
    check({tag, "_idx"}, 32'(hit_idx), 32'(exp_idx));
  endtask

  logic [11:0] ol_exp;

  initial begin
    rst_n = 1'b0; pix_x_in = '0; pix_y_in = '0; in_screen = 1'b0; frame_start = 1'b0;
    cfg_valid = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_outline = 1'b0;
    cfg_x = '0; cfg_w = '0; cfg_y = '0; cfg_h = '0; cfg_rgb = '0;
    #3;
    check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h000);
    check("rst_hv", 32'(hit_valid), 32'd0);
    check("rst_idx", 32'(hit_idx), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_err", 32'(cfg_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1. Empty table: background everywhere.
    for (int i = 0; i < 4; i++) probe("empty", 11'(i * 300), 10'(i * 200), 1'b1, 12'h000, 1'b0, 3'd0);
    check("empty_ready", 32'(cfg_ready), 32'd1);

    // 2. Shadow write invisible until commit.
    cfg_write(4'd2, 1'b1, 1'b0, 11'd10, 11'd4, 10'd5, 10'd2, 12'hF00);
    probe("pre_commit", 11'd10, 10'd5, 1'b1, 12'h000, 1'b0, 3'd0);
    commit();
    probe("s2_tl", 11'd10, 10'd5, 1'b1, 12'hF00, 1'b1, 3'd2);
    probe("s2_br", 11'd13, 10'd6, 1'b1, 12'hF00, 1'b1, 3'd2);
    probe("s2_right", 11'd14, 10'd5, 1'b1, 12'h000, 1'b0, 3'd0);
    probe("s2_below", 11'd10, 10'd7, 1'b1, 12'h000, 1'b0, 3'd0);
    probe("s2_left", 11'd9, 10'd5, 1'b1, 12'h000, 1'b0, 3'd0);

    // 3. Priority between overlapping slots 0 and 3.
    cfg_write(4'd0, 1'b1, 1'b0, 11'd0, 11'd100, 10'd0, 10'd100, 12'h0F0);
    cfg_write(4'd3, 1'b1, 1'b0, 11'd50, 11'd100, 10'd50, 10'd100, 12'h00F);
    commit();
    probe("pri_overlap", 11'd60, 10'd60, 1'b1, 12'h0F0, 1'b1, 3'd0);
    probe("pri_slot3", 11'd120, 10'd120, 1'b1, 12'h00F, 1'b1, 3'd3);
    probe("pri_s3_last", 11'd149, 10'd149, 1'b1, 12'h00F, 1'b1, 3'd3);
    probe("pri_s3_out", 11'd150, 10'd150, 1'b1, 12'h000, 1'b0, 3'd0);
    probe("offscreen", 11'd60, 10'd60, 1'b0, 12'h000, 1'b0, 3'd0);

    // 4. Write coinciding with frame_start, then a stalled write.
    cfg_idx = 4'd4; cfg_en = 1'b1; cfg_outline = 1'b0;
    cfg_x = 11'd200; cfg_w = 11'd10; cfg_y = 10'd200; cfg_h = 10'd10; cfg_rgb = 12'h0FF;
    cfg_valid = 1'b1; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    cfg_idx = 4'd5; cfg_x = 11'd300; cfg_y = 10'd300; cfg_rgb = 12'hF0F;
    check("commit_ready", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    check("post_commit_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    probe("fs_write", 11'd205, 10'd205, 1'b1, 12'h0FF, 1'b1, 3'd4);
    probe("stalled_shadow", 11'd305, 10'd305, 1'b1, 12'h000, 1'b0, 3'd0);
    commit();
    probe("stalled_commit", 11'd305, 10'd305, 1'b1, 12'hF0F, 1'b1, 3'd5);

    // 5. Out-of-range index, far-edge no-wrap, zero width.
    cfg_idx = 4'd8; cfg_en = 1'b1; cfg_outline = 1'b0;
    cfg_x = 11'd0; cfg_w = 11'd1000; cfg_y = 10'd0; cfg_h = 10'd1000; cfg_rgb = 12'hABC;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("err_pulse", 32'(cfg_err), 32'd1);
    @(posedge clk); #1;
    check("err_clear", 32'(cfg_err), 32'd0);
    cfg_write(4'd6, 1'b1, 1'b0, 11'd2040, 11'd20, 10'd900, 10'd10, 12'h123);
    cfg_write(4'd7, 1'b1, 1'b0, 11'd400, 11'd0, 10'd400, 10'd5, 12'hFFF);
    commit();
    probe("err_no_write", 11'd500, 10'd500, 1'b1, 12'h000, 1'b0, 3'd0);
    probe("err_slot0_kept", 11'd60, 10'd60, 1'b1, 12'h0F0, 1'b1, 3'd0);
    probe("nowrap_2047", 11'd2047, 10'd905, 1'b1, 12'h123, 1'b1, 3'd6);
    probe("nowrap_0", 11'd0, 10'd905, 1'b1, 12'h000, 1'b0, 3'd0);
    probe("zero_w", 11'd400, 10'd401, 1'b1, 12'h000, 1'b0, 3'd0);

    // 6. Outline on slot 0.
`ifdef VGA_COMP_OUTLINE_EN
    ol_exp = 12'hFFF;
`else
    ol_exp = 12'hF00;
`endif
    cfg_write(4'd0, 1'b1, 1'b1, 11'd8, 11'd4, 10'd8, 10'd4, 12'hF00);
    commit();
    probe("ol_edge", 11'd8, 10'd9, 1'b1, ol_exp, 1'b1, 3'd0);
    probe("ol_inner", 11'd9, 10'd9, 1'b1, 12'hF00, 1'b1, 3'd0);
    probe("ol_corner", 11'd11, 10'd11, 1'b1, ol_exp, 1'b1, 3'd0);

    // Asynchronous reset mid-frame clears outputs immediately.
    pix_x_in = 11'd9; pix_y_in = 10'd9; in_screen = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'hF00);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h000);
    check("midrst_hv", 32'(hit_valid), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    probe("post_rst", 11'd9, 10'd9, 1'b1, 12'h000, 1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
